// File: rtl/inst_mem_ctrl.sv
// Byte-addressed instruction memory with a fixed-latency fetch port, a byte-wide
// program-load port, flush/kill of the in-flight fetch and a delivered-fetch counter.
module inst_mem_ctrl #(
    parameter int          DEPTH_BYTES = 1024,
    parameter int          LATENCY     = 1,
    parameter              INIT_FILE   = "",
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_misalign,
    output logic        rsp_oob,
    input  logic        load_en,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_data,
    output logic [31:0] fetch_cnt
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD} state_t;

    state_t      state;
    logic [7:0]  mem [DEPTH_BYTES];
    logic [31:0] addr_p0;
    logic [3:0]  cnt_p0;
    logic        vld_p1;

    logic          rsp_cycle;
    logic          accept;
    logic          fire;
    logic [31:0]   fa;
    logic [AW-1:0] idx;
    logic          fa_mis;
    logic          fa_oob;
    logic [31:0]   fa_word;

    // A response cycle in WAIT can take the next request, so throughput is one per LATENCY.
    assign rsp_cycle = (state == S_WAIT) && vld_p1;
    assign req_ready = ((state == S_IDLE) || rsp_cycle) && !load_en && !flush && !rst;
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the word is read straight off the request address at the accept edge.
    assign fire = (LATENCY == 1) ? accept
                                 : ((state == S_WAIT) && (cnt_p0 == 4'd1) && !flush);
    assign fa   = (LATENCY == 1) ? req_addr : addr_p0;

    assign idx     = fa[AW-1:0];
    assign fa_mis  = (fa[1:0] != 2'b00);
    assign fa_oob  = ({1'b0, fa} + 33'd3) >= 33'(DEPTH_BYTES);
    assign fa_word = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};

    // A flushed response is suppressed in the very cycle it would have been presented.
    assign rsp_valid = vld_p1 && !flush;

    // p0: request address capture
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0 <= req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_LOAD) && load_we && (load_addr < 32'(DEPTH_BYTES))) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    // p1: control FSM, response registers and delivered-fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt_p0       <= 4'd0;
            vld_p1       <= 1'b0;
            rsp_data     <= 32'd0;
            rsp_misalign <= 1'b0;
            rsp_oob      <= 1'b0;
            fetch_cnt    <= 32'd0;
        end else begin
            vld_p1 <= fire;
            if (fire) begin
                rsp_data     <= (fa_mis || fa_oob) ? NOP_WORD : fa_word;
                rsp_misalign <= fa_mis;
                rsp_oob      <= fa_oob;
            end
            if (vld_p1 && !flush) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= S_WAIT;
                        cnt_p0 <= 4'(LATENCY - 1);
                    end else if (load_en) begin
                        state <= S_LOAD;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state  <= S_IDLE;
                        cnt_p0 <= 4'd0;
                    end else if (rsp_cycle) begin
                        if (accept) begin
                            cnt_p0 <= 4'(LATENCY - 1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (cnt_p0 != 4'd0) begin
                        cnt_p0 <= cnt_p0 - 4'd1;
                    end
                end
                S_LOAD: begin
                    if (!load_en) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Scoreboard bench for inst_mem_ctrl: directed fetches push hand-computed responses,
// a negedge monitor pops and compares data, flags and arrival cycle.
module tb_inst_mem_ctrl;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_misalign;
    logic        rsp_oob;
    logic        load_en;
    logic        load_we;
    logic [31:0] load_addr;
    logic [7:0]  load_data;
    logic [31:0] fetch_cnt;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        oob;
        int          at;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    inst_mem_ctrl #(
        .DEPTH_BYTES(DEPTH),
        .LATENCY    (LAT),
        .NOP_WORD   (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .flush       (flush),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_misalign(rsp_misalign),
        .rsp_oob     (rsp_oob),
        .load_en     (load_en),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got data %h at cycle %0d want no response", rsp_data, cyc);
            end else begin
                e = sbq.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_misalign", {31'd0, rsp_misalign}, {31'd0, e.mis});
                chk("rsp_oob", {31'd0, rsp_oob}, {31'd0, e.oob});
                chk("rsp_cycle", cyc, e.at);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic m, input logic o);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready_for_fetch", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        sbq.push_back('{d, m, o, cyc + LAT});
        step();
        req_valid = 1'b0;
        req_addr  = 32'hDEADBEEF;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < LAT + 10) begin
            step();
            n++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d responses missing want 0", sbq.size());
            sbq.delete();
        end
        step();
    endtask

    task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_we = 1'b0;
    endtask

    logic [31:0] prog_a [17] = '{0, 1, 2, 3, 64, 4, 5, 6, 7, 8, 9, 10, 11, 60, 61, 62, 63};
    logic [7:0]  prog_d [17] = '{8'hB7, 8'h40, 8'h06, 8'h00, 8'hAA, 8'h13, 8'h05, 8'h10, 8'h00,
                                 8'h93, 8'h05, 8'h20, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; flush = 1'b0;
        load_en = 1'b0; load_we = 1'b0; load_addr = 32'd0; load_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_misalign", {31'd0, rsp_misalign}, 32'd0);
        chk("rst_oob", {31'd0, rsp_oob}, 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Program load, including an out-of-range byte that must not alias onto address 0
        load_en = 1'b1;
        step();
        for (int i = 0; i < 17; i++) load_byte(prog_a[i], prog_d[i]);
        load_en = 1'b0;
        step();
        load_byte(32'd8, 8'hEE);

        // Held request: first captured address wins, ready low until the response cycle
        req_valid = 1'b1;
        req_addr  = 32'd0;
        sbq.push_back('{32'h000640B7, 1'b0, 1'b0, cyc + LAT});
        step();
        req_addr = 32'd4;
        chk("b2b_ready_n1", {31'd0, req_ready}, 32'd0);
        step();
        chk("b2b_ready_n2", {31'd0, req_ready}, 32'd0);
        step();
        chk("b2b_ready_n3", {31'd0, req_ready}, 32'd1);
        sbq.push_back('{32'h00100513, 1'b0, 1'b0, cyc + LAT});
        step();
        req_valid = 1'b0;
        drain();

        fetch(32'd8,  32'h00200593, 1'b0, 1'b0);
        fetch(32'd60, 32'h44332211, 1'b0, 1'b0);
        fetch(32'd2,  NOP, 1'b1, 1'b0);
        fetch(32'd62, NOP, 1'b1, 1'b1);
        fetch(32'd61, NOP, 1'b1, 1'b1);
        fetch(32'd64, NOP, 1'b0, 1'b1);
        fetch(32'hFFFFFFFC, NOP, 1'b0, 1'b1);
        drain();
        chk("cnt_after_fetches", fetch_cnt, 32'd9);

        // Flush mid-flight
        req_valid = 1'b1;
        req_addr  = 32'd4;
        step();
        req_valid = 1'b0;
        step();
        flush = 1'b1;
        #1;
        chk("flush_ready", {31'd0, req_ready}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("post_flush_ready", {31'd0, req_ready}, 32'd1);
        repeat (LAT + 2) step();
        chk("cnt_after_flush", fetch_cnt, 32'd9);

        // Flush landing on the response cycle itself
        req_valid = 1'b1;
        req_addr  = 32'd4;
        step();
        req_valid = 1'b0;
        repeat (LAT - 1) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (2) step();
        chk("cnt_after_rsp_flush", fetch_cnt, 32'd9);

        // load_en during WAIT: response still arrives, writes before LOAD are dropped
        req_valid = 1'b1;
        req_addr  = 32'd4;
        sbq.push_back('{32'h00100513, 1'b0, 1'b0, cyc + LAT});
        step();
        req_valid = 1'b0;
        load_en   = 1'b1;
        load_we   = 1'b1;
        load_addr = 32'd6;
        load_data = 8'h99;
        step();
        step();
        load_we = 1'b0;
        chk("load_en_blocks_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) step();
        load_byte(32'd5, 8'h55);
        load_byte(32'd64, 8'hAA);
        load_en = 1'b0;
        step();
        drain();
        chk("cnt_after_load_wait", fetch_cnt, 32'd10);
        fetch(32'd4, 32'h00105513, 1'b0, 1'b0);
        fetch(32'd0, 32'h000640B7, 1'b0, 1'b0);
        drain();
        chk("cnt_after_reload", fetch_cnt, 32'd12);

        // Reset while a fetch is in flight
        req_valid = 1'b1;
        req_addr  = 32'd8;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("wait_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("wait_rst_data", rsp_data, 32'd0);
        chk("wait_rst_flags", {30'd0, rsp_misalign, rsp_oob}, 32'd0);
        chk("wait_rst_cnt", fetch_cnt, 32'd0);
        repeat (LAT + 2) step();
        fetch(32'd60, 32'h44332211, 1'b0, 1'b0);
        drain();
        chk("cnt_after_rst", fetch_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
